// File: rtl/bus_pkg.sv
// bus_pkg: shared bus arbitration types and defaults
package bus_pkg;
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      BUSY       = 3'd1,
      SPLIT      = 3'd2,
      SPLIT_BUSY = 3'd3,
      RESUME     = 3'd4
   } arb_state_e;
   localparam int DEF_NUM_MASTERS = 2;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin winner search starting after the last grant, skipping excluded masters
module rr_picker #(
   parameter int NUM_MASTERS = 2,
   parameter int SEL_WIDTH   = 1
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [SEL_WIDTH-1:0]   last_i,
   input  logic [NUM_MASTERS-1:0] excl_i,
   output logic [SEL_WIDTH-1:0]   idx_o,
   output logic                   valid_o
);
   // scan from farthest to nearest offset so the closest eligible master wins
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         if (req_i[(int'(last_i) + k) % NUM_MASTERS] && !excl_i[(int'(last_i) + k) % NUM_MASTERS]) begin
            idx_o   = SEL_WIDTH'((int'(last_i) + k) % NUM_MASTERS);
            valid_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus ownership with split-transaction parking and resume
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int SEL_WIDTH   = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] mreq,
   input  logic                   ssplit,
   output logic [NUM_MASTERS-1:0] mgrant,
   output logic [SEL_WIDTH-1:0]   msel,
   output logic [NUM_MASTERS-1:0] msplit,
   output logic                   bus_busy
);
   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d, msplit_q, msplit_d, excl;
   logic [SEL_WIDTH-1:0]   sel_q, sel_d, last_q, last_d, sid_q, sid_d, pick;
   logic                   pick_v;
   // the parked master may not win the bus while it waits for its slave
   always_comb begin
      excl       = '0;
      excl[sid_q] = (state_q == SPLIT);
   end
   rr_picker #(.NUM_MASTERS(NUM_MASTERS), .SEL_WIDTH(SEL_WIDTH)) u_pick (
      .req_i  (mreq),
      .last_i (last_q),
      .excl_i (excl),
      .idx_o  (pick),
      .valid_o(pick_v)
   );
   // next-state, grant, split bookkeeping; release beats split, resume beats new requests
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      sel_d    = sel_q;
      last_d   = last_q;
      sid_d    = sid_q;
      msplit_d = msplit_q;
      case (state_q)
         IDLE: if (pick_v) begin
            grant_d        = '0;
            grant_d[pick]  = 1'b1;
            sel_d          = pick;
            last_d         = pick;
            msplit_d[pick] = 1'b0;
            state_d        = BUSY;
         end
         BUSY: if (!mreq[sel_q]) begin
            grant_d = '0;
            state_d = IDLE;
         end else if (ssplit) begin
            sid_d           = sel_q;
            grant_d         = '0;
            msplit_d[sel_q] = 1'b1;
            state_d         = SPLIT;
         end
         SPLIT: if (!mreq[sid_q]) begin
            msplit_d[sid_q] = 1'b0;
            sid_d           = '0;
            state_d         = IDLE;
         end else if (!ssplit) begin
            grant_d         = '0;
            grant_d[sid_q]  = 1'b1;
            sel_d           = sid_q;
            last_d          = sid_q;
            msplit_d[sid_q] = 1'b0;
            state_d         = RESUME;
         end else if (pick_v) begin
            grant_d        = '0;
            grant_d[pick]  = 1'b1;
            sel_d          = pick;
            last_d         = pick;
            msplit_d[pick] = 1'b0;
            state_d        = SPLIT_BUSY;
         end
         SPLIT_BUSY: if (!mreq[sid_q]) begin
            msplit_d[sid_q] = 1'b0;
            sid_d           = '0;
            grant_d         = mreq[sel_q] ? grant_q : '0;
            state_d         = mreq[sel_q] ? BUSY : IDLE;
         end else if (!ssplit) begin
            msplit_d[sel_q] = 1'b1;
            grant_d         = '0;
            grant_d[sid_q]  = 1'b1;
            sel_d           = sid_q;
            last_d          = sid_q;
            msplit_d[sid_q] = 1'b0;
            state_d         = RESUME;
         end else if (!mreq[sel_q]) begin
            grant_d = '0;
            state_d = SPLIT;
         end
         RESUME: if (!mreq[sel_q]) begin
            grant_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state registers; reset drops every grant at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         sel_q    <= '0;
         last_q   <= SEL_WIDTH'(NUM_MASTERS - 1);
         sid_q    <= '0;
         msplit_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         sel_q    <= sel_d;
         last_q   <= last_d;
         sid_q    <= sid_d;
         msplit_q <= msplit_d;
      end
   end
   assign mgrant   = grant_q;
   assign msel     = sel_q;
   assign msplit   = msplit_q;
   assign bus_busy = |grant_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random stimulus against an ownership-level reference model
module tb_bus_arbiter;
   localparam int N  = 2;
   localparam int SW = 1;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  mreq = '0;
   logic          ssplit = 1'b0;
   logic [N-1:0]  mgrant, msplit;
   logic [SW-1:0] msel;
   logic          bus_busy;
   int            n_chk = 0;
   int            n_fail = 0;
   int            own, park, last, sel;
   bit            resumed;
   logic [N-1:0]  ms;

   bus_arbiter #(.NUM_MASTERS(N), .SEL_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .mreq(mreq), .ssplit(ssplit),
      .mgrant(mgrant), .msel(msel), .msplit(msplit), .bus_busy(bus_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int ex);
      for (int k = 1; k <= N; k++) begin
         int j = (last + k) % N;
         if (r[j] && j != ex) return j;
      end
      return -1;
   endfunction

   task automatic mreset();
      own = -1; park = -1; last = N - 1; sel = 0; resumed = 0; ms = '0;
   endtask

   task automatic give(input int w);
      own = w; sel = w; last = w; ms[w] = 1'b0;
   endtask

   // own: current owner, park: master waiting on a split slave, resumed: owner came back from split
   task automatic step();
      int w;
      if (rst) begin
         mreset();
         return;
      end
      if (park < 0) begin
         if (own < 0) begin
            w = pick(mreq, -1);
            if (w >= 0) begin give(w); resumed = 0; end
         end else if (!mreq[own]) begin
            own = -1; resumed = 0;
         end else if (!resumed && ssplit) begin
            park = own; ms[own] = 1'b1; own = -1;
         end
      end else if (!mreq[park]) begin
         ms[park] = 1'b0; park = -1;
         if (own >= 0 && !mreq[own]) own = -1;
      end else if (!ssplit) begin
         if (own >= 0) ms[own] = 1'b1;
         give(park); park = -1; resumed = 1;
      end else if (own >= 0) begin
         if (!mreq[own]) own = -1;
      end else begin
         w = pick(mreq, park);
         if (w >= 0) give(w);
      end
   endtask

   task automatic cmp();
      logic [N-1:0] g;
      g = '0;
      if (own >= 0) g[own] = 1'b1;
      check("mgrant", mgrant, g);
      check("msel", msel, sel);
      check("msplit", msplit, ms);
      check("bus_busy", bus_busy, own >= 0);
   endtask

   task automatic cyc(input logic [N-1:0] r, input logic s, input int n);
      for (int i = 0; i < n; i++) begin
         mreq = r; ssplit = s;
         @(posedge clk);
         step();
         #1 cmp();
      end
   endtask

   initial begin
      logic [N-1:0] r;
      logic s;
      mreset();
      cyc(2'b00, 1'b0, 2);
      rst = 1'b0;
      cyc(2'b01, 1'b0, 1);
      check("first_grant", mgrant, 2'b01);
      cyc(2'b01, 1'b0, 4);
      cyc(2'b00, 1'b0, 2);
      cyc(2'b11, 1'b0, 3);
      cyc(2'b10, 1'b0, 4);
      cyc(2'b01, 1'b0, 4);
      cyc(2'b00, 1'b0, 2);
      cyc(2'b01, 1'b0, 2);
      cyc(2'b01, 1'b1, 4);
      check("split_idle_msplit", msplit, 2'b01);
      cyc(2'b01, 1'b0, 1);
      check("resume_idle_grant", mgrant, 2'b01);
      cyc(2'b01, 1'b0, 2);
      cyc(2'b00, 1'b0, 2);
      cyc(2'b01, 1'b0, 2);
      cyc(2'b01, 1'b1, 1);
      cyc(2'b11, 1'b1, 3);
      check("split_busy_grant", mgrant, 2'b10);
      cyc(2'b11, 1'b0, 1);
      check("preempt_grant", mgrant, 2'b01);
      check("preempt_msplit", msplit, 2'b10);
      cyc(2'b10, 1'b0, 2);
      check("regrant_m1", mgrant, 2'b10);
      check("regrant_msplit", msplit, 2'b00);
      cyc(2'b00, 1'b0, 2);
      cyc(2'b01, 1'b0, 2);
      cyc(2'b01, 1'b1, 1);
      cyc(2'b11, 1'b1, 3);
      rst = 1'b1;
      #1;
      check("async_rst_mgrant", mgrant, 0);
      check("async_rst_msplit", msplit, 0);
      check("async_rst_msel", msel, 0);
      check("async_rst_busy", bus_busy, 0);
      mreset();
      cyc(2'b11, 1'b0, 1);
      rst = 1'b0;
      cyc(2'b11, 1'b0, 1);
      check("post_rst_m0_first", mgrant, 2'b01);
      cyc(2'b00, 1'b0, 2);
      r = '0; s = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
         if ($urandom_range(5) == 0) s = ~s;
         cyc(r, s, 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
